// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FSM state enum, instruction width, PC step and FIFO entry layout.
package instruction_fetch_unit_pkg;

  localparam int unsigned ILEN = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [31:0]     pc4;
  } fe_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry output FIFO of {instruction, PC+4} for the fetch unit.
// Entry 0 is always the head; flush wins over push and pop.
module fetch_skid_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  fe_entry_t  din,
  output fe_entry_t  head,
  output logic [1:0] count
);

  fe_entry_t ent0;
  fe_entry_t ent1;
  logic      full;

  assign full = (count == 2'(BUF_DEPTH));
  assign head = ent0;

  // Shift-style storage: pops move entry 1 forward into the head slot.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b11: begin
          if (full) begin
            ent0 <= ent1;
            ent1 <= din;
          end else begin
            ent0 <= din;
          end
        end
        2'b10: begin
          if (count == 2'd0) ent0 <= din;
          else               ent1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, request FSM and output skid buffer.
// Optional FETCH_MISALIGN_CHK_EN adds a sticky MisalignErr output.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Stall,
  input  logic            RedirectValid,
  input  logic [31:0]     RedirectPC,
  output logic            ImemReq,
  output logic [31:0]     ImemAddr,
  input  logic            ImemAck,
  input  logic [ILEN-1:0] ImemRdata,
  output logic [ILEN-1:0] InstructionOut,
  output logic [31:0]     PC4Out,
  output logic            ValidOut
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic            MisalignErr
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  redir_pc;
  logic         req;
  logic         push;
  logic         pop;
  logic         flush;
  fe_entry_t    head;
  fe_entry_t    din;
  logic [1:0]   count;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_pc = {RedirectPC[31:2], 2'b00};

  // Sticky flag for any redirect to a non-word-aligned target.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      MisalignErr <= 1'b0;
    else if (RedirectValid && (RedirectPC[1:0] != 2'b00))
      MisalignErr <= 1'b1;
  end
`else
  assign redir_pc = RedirectPC;
`endif

  assign ImemReq  = req & Rst_n;
  assign ImemAddr = (state_q == FETCH) ? pc_q : addr_q;
  assign ValidOut = (count != 2'd0);
  assign pop      = ValidOut & ~Stall;
  assign din      = '{instr: ImemRdata, pc4: pc_q + PC_INC};

  assign InstructionOut = head.instr;
  assign PC4Out         = head.pc4;

  // State, fetch PC and outstanding-request address registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  // Next state; a redirect overrides PC and flushes regardless of ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req     = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      FETCH: begin
        req = (count < 2'(BUF_DEPTH)) && !RedirectValid;
        if (req) begin
          if (ImemAck) begin
            push = 1'b1;
            pc_d = pc_q + PC_INC;
          end else begin
            state_d = WAIT;
            addr_d  = pc_q;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (ImemAck) begin
          state_d = FETCH;
          if (!RedirectValid) begin
            push = 1'b1;
            pc_d = pc_q + PC_INC;
          end
        end else if (RedirectValid) begin
          state_d = DROP;
        end
      end
      DROP: begin
        req = 1'b1;
        if (ImemAck) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (RedirectValid) begin
      pc_d  = redir_pc;
      flush = 1'b1;
    end
  end

  fetch_skid_buffer #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (din),
    .head (head),
    .count(count)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: random memory latency, stalls, redirects.
// Reference model is a queue of expected entries plus a fetch PC.
module tb_instruction_fetch_unit;

  logic        Clk;
  logic        Rst_n;
  logic        Stall;
  logic        RedirectValid;
  logic [31:0] RedirectPC;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRdata;
  logic [31:0] InstructionOut;
  logic [31:0] PC4Out;
  logic        ValidOut;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        MisalignErr;
`endif

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Stall         (Stall),
    .RedirectValid (RedirectValid),
    .RedirectPC    (RedirectPC),
    .ImemReq       (ImemReq),
    .ImemAddr      (ImemAddr),
    .ImemAck       (ImemAck),
    .ImemRdata     (ImemRdata),
    .InstructionOut(InstructionOut),
    .PC4Out        (PC4Out),
    .ValidOut      (ValidOut)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .MisalignErr   (MisalignErr)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_cons = 0;
  int ack_delay = 0;

  logic [63:0] q[$];
  logic [31:0] mpc;
  logic        pend;
  logic        stale;
  logic [31:0] raddr;
  int          dly;

  logic        last_req;
  logic [31:0] last_addr;
  logic        last_valid;
  logic [31:0] last_pc4;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHK_EN
    return {t[31:2], 2'b00};
`else
    return t;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    mpc   = 32'h0;
    pend  = 1'b0;
    stale = 1'b0;
  endtask

  // Called at a negedge; drives one cycle, checks, updates model.
  task automatic step(input logic st, input logic rv,
                      input logic [31:0] rpc);
    logic was_pend;
    logic ack;
    logic exp_req;
    Stall = st;
    RedirectValid = rv;
    RedirectPC = rpc;
    ImemAck = 1'b0;
    ImemRdata = 32'h0;
    #1;
    was_pend   = pend;
    last_req   = ImemReq;
    last_addr  = ImemAddr;
    last_valid = ValidOut;
    last_pc4   = PC4Out;
    n_checks++;
    if (ValidOut !== (q.size() != 0)) begin
      n_fail++;
      $display("FAIL valid: got %b want %b", ValidOut, q.size() != 0);
    end
    if (q.size() != 0) begin
      n_checks++;
      if ({InstructionOut, PC4Out} !== q[0]) begin
        n_fail++;
        $display("FAIL head: got %h/%h want %h/%h", InstructionOut,
                 PC4Out, q[0][63:32], q[0][31:0]);
      end
    end
    if (!was_pend) begin
      exp_req = !rv && (q.size() <= 1);
      n_checks++;
      if (ImemReq !== exp_req) begin
        n_fail++;
        $display("FAIL req: got %b want %b", ImemReq, exp_req);
      end
      if (ImemReq === 1'b1) begin
        n_checks++;
        if (ImemAddr !== mpc) begin
          n_fail++;
          $display("FAIL addr: got %h want %h", ImemAddr, mpc);
        end
        pend  = 1'b1;
        raddr = ImemAddr;
        dly   = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
      end
    end else begin
      n_checks++;
      if (ImemReq !== 1'b1 || ImemAddr !== raddr) begin
        n_fail++;
        $display("FAIL hold: got %b/%h want 1/%h", ImemReq, ImemAddr,
                 raddr);
      end
    end
    ack = pend && (dly == 0);
    ImemAck = ack;
    ImemRdata = ack ? mem(raddr) : $urandom;
    if (!st && q.size() != 0) begin
      void'(q.pop_front());
      n_cons++;
    end
    if (rv) begin
      q.delete();
      mpc = tgt_of(rpc);
      if (pend && !ack) stale = 1'b1;
    end else if (ack && !stale) begin
      q.push_back({mem(mpc), mpc + 32'd4});
      mpc = mpc + 32'd4;
    end
    if (ack) begin
      pend  = 1'b0;
      stale = 1'b0;
    end else if (pend) begin
      dly--;
    end
    @(negedge Clk);
  endtask

  // Called at a negedge; asserts reset, checks reset values, releases.
  task automatic do_reset();
    Rst_n = 1'b0;
    Stall = 1'b0;
    RedirectValid = 1'b0;
    ImemAck = 1'b0;
    #1;
    n_checks++;
    if (ImemReq !== 1'b0 || ValidOut !== 1'b0 ||
        InstructionOut !== 32'h0 || PC4Out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_vals: req %b valid %b ins %h pc4 %h want 0",
               ImemReq, ValidOut, InstructionOut, PC4Out);
    end
`ifdef FETCH_MISALIGN_CHK_EN
    n_checks++;
    if (MisalignErr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_misalign: got %b want 0", MisalignErr);
    end
`endif
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ack_delay = 0;
    do_reset();
    step(0, 0, 0);
    n_checks++;
    if (last_req !== 1'b1 || last_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL first_req: got %b/%h want 1/0", last_req, last_addr);
    end
  endtask

  task automatic test_stream();
    ack_delay = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0);
      if (k < 3) begin
        n_checks++;
        if (last_addr !== 32'(4 * k)) begin
          n_fail++;
          $display("FAIL stream_addr%0d: got %h want %h", k, last_addr,
                   32'(4 * k));
        end
      end
      if (k >= 1) begin
        n_checks++;
        if (last_valid !== 1'b1 || last_pc4 !== 32'(4 * k)) begin
          n_fail++;
          $display("FAIL stream_pc4%0d: got %b/%h want 1/%h", k,
                   last_valid, last_pc4, 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] s_pc4;
    int n0;
    ack_delay = 0;
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    s_pc4 = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      if (i == 0) s_pc4 = last_pc4;
      n_checks++;
      if (last_valid !== 1'b1 || last_pc4 !== s_pc4) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %b/%h want 1/%h", i,
                 last_valid, last_pc4, s_pc4);
      end
    end
    n_checks++;
    if (last_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_req: got %b want 0", last_req);
    end
    n0 = n_cons;
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    n_checks++;
    if (n_cons - n0 !== 4) begin
      n_fail++;
      $display("FAIL stall_release: got %0d want 4", n_cons - n0);
    end
  endtask

  task automatic test_redirect_wait();
    int i;
    ack_delay = 3;
    do_reset();
    step(0, 0, 0);
    step(0, 1, 32'h100);
    i = 0;
    do begin
      step(0, 0, 0);
      i++;
    end while (!(last_req === 1'b1 && last_addr !== 32'h0) && i < 12);
    n_checks++;
    if (last_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL drop_addr: got %h want 00000100", last_addr);
    end
    i = 0;
    do begin
      step(0, 0, 0);
      i++;
    end while (last_valid !== 1'b1 && i < 12);
    n_checks++;
    if (last_valid !== 1'b1 || last_pc4 !== 32'h104) begin
      n_fail++;
      $display("FAIL drop_pc4: got %b/%h want 1/00000104", last_valid,
               last_pc4);
    end
  endtask

  task automatic test_redirect_ack();
    ack_delay = 1;
    do_reset();
    step(0, 0, 0);
    step(0, 1, 32'h40);
    ack_delay = 0;
    step(0, 0, 0);
    n_checks++;
    if (last_valid !== 1'b0 || last_addr !== 32'h40 || last_req !== 1'b1)
    begin
      n_fail++;
      $display("FAIL redir_ack: got v%b r%b %h want v0 r1 00000040",
               last_valid, last_req, last_addr);
    end
  endtask

  task automatic test_reset_mid();
    ack_delay = 0;
    do_reset();
    step(0, 0, 0);
    ack_delay = 3;
    step(1, 0, 0);
    #2;
    Rst_n = 1'b0;
    #1;
    n_checks++;
    if (ImemReq !== 1'b0 || ValidOut !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: req %b valid %b want 0/0", ImemReq,
               ValidOut);
    end
    @(negedge Clk);
    do_reset();
    ack_delay = 0;
    step(0, 0, 0);
    n_checks++;
    if (last_req !== 1'b1 || last_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_addr: got %b/%h want 1/0", last_req,
               last_addr);
    end
  endtask

  task automatic test_wrap();
    ack_delay = 0;
    do_reset();
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    step(0, 0, 0);
    n_checks++;
    if (last_pc4 !== 32'h0 || last_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap: got pc4 %h addr %h want 0/0", last_pc4,
               last_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    int n0;
    ack_delay = -1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                      : ($urandom & 32'h0000_FFFC);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8, t);
    end
    n0 = n_cons;
    for (int i = 0; i < 40; i++) step(0, 0, 0);
    n_checks++;
    if (n_cons - n0 < 5) begin
      n_fail++;
      $display("FAIL liveness: got %0d want >=5", n_cons - n0);
    end
  endtask

`ifdef FETCH_MISALIGN_CHK_EN
  task automatic test_misalign();
    ack_delay = 0;
    do_reset();
    step(0, 1, 32'h102);
    step(0, 0, 0);
    n_checks++;
    if (MisalignErr !== 1'b1 || last_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL misalign: got %b/%h want 1/00000100", MisalignErr,
               last_addr);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    n_checks++;
    if (MisalignErr !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_sticky: got %b want 1", MisalignErr);
    end
  endtask
`endif

  initial begin
    Rst_n = 1'b0;
    Stall = 1'b0;
    RedirectValid = 1'b0;
    RedirectPC = 32'h0;
    ImemAck = 1'b0;
    ImemRdata = 32'h0;
    model_reset();
    @(negedge Clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_reset_mid();
    test_wrap();
`ifdef FETCH_MISALIGN_CHK_EN
    test_misalign();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
